// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar front end: state codes, default timing
// constants and a saturating 3-digit BCD increment helper.
package sonar_pkg;

  localparam int unsigned CLK_HZ_DEF        = 50_000_000;
  localparam int unsigned CYCLES_PER_CM_DEF = 2941;
  localparam int unsigned BCD_W             = 12;

  localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;

  typedef enum logic [2:0] {
    INICIAL       = 3'd0,
    PREPARACAO    = 3'd1,
    ENVIA_TRIGGER = 3'd2,
    ESPERA_ECHO   = 3'd3,
    MEDE          = 3'd4,
    ARMAZENA      = 3'd5,
    FINAL_MEDIDA  = 3'd6
  } estado_t;

  // Add one to a 3-digit BCD value, holding at 999.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    if (v != BCD_MAX) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_cm.sv
// Echo-width to centimetre converter: per-cm cycle tick counter feeding a
// saturating BCD accumulator. MEDIDA_ARREDONDA_EN exposes the half-cm flag.
module contador_cm
  import sonar_pkg::*;
#(
  parameter int unsigned CYCLES_PER_CM = CYCLES_PER_CM_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             conta,
  input  logic             arredonda,
`ifdef MEDIDA_ARREDONDA_EN
  output logic             meio,
`endif
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned TICK_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CYCLES_PER_CM - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;

  always_comb begin
    tick_d = tick_q;
    bcd_d  = bcd_q;
    if (clear) begin
      tick_d = '0;
      bcd_d  = '0;
    end else if (conta) begin
      if (tick_q == TICK_MAX) begin
        tick_d = '0;
        bcd_d  = bcd_inc(bcd_q);
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end else if (arredonda) begin
      bcd_d = bcd_inc(bcd_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_q <= '0;
      bcd_q  <= '0;
    end else begin
      tick_q <= tick_d;
      bcd_q  <= bcd_d;
    end
  end

`ifdef MEDIDA_ARREDONDA_EN
  localparam logic [TICK_W-1:0] TICK_MEIO = TICK_W'(CYCLES_PER_CM / 2);
  assign meio = (tick_q >= TICK_MEIO);
`endif

  assign bcd = bcd_q;

endmodule

// File: rtl/interface_hcsr04.sv
// HC-SR04 front end: trigger generation, echo synchronisation and timing FSM.
// Define MEDIDA_ARREDONDA_EN to round the result to the nearest centimetre.
module interface_hcsr04
  import sonar_pkg::*;
#(
  parameter int unsigned CLK_HZ        = CLK_HZ_DEF,
  parameter int unsigned TRIGGER_US    = 10,
  parameter int unsigned CYCLES_PER_CM = CYCLES_PER_CM_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             medir,
  input  logic             echo,
  output logic             trigger,
  output logic             pronto,
  output logic [BCD_W-1:0] medida,
  output logic [2:0]       db_estado
);

  localparam int unsigned TRIGGER_CYCLES = CLK_HZ / 1_000_000 * TRIGGER_US;
  localparam int unsigned TRIG_W         = $clog2(TRIGGER_CYCLES + 1);
  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIGGER_CYCLES - 1);

  estado_t           estado_q, estado_d;
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic              echo_meta_q, echo_s_q, echo_prev_q;
  logic              trigger_q, pronto_q;
  logic [BCD_W-1:0]  medida_q, medida_d;
  logic              clear, conta, arredonda;
  logic [BCD_W-1:0]  bcd;
  logic              echo_sobe, echo_desce;
`ifdef MEDIDA_ARREDONDA_EN
  logic              meio;
`endif

  assign echo_sobe  = echo_s_q & ~echo_prev_q;
  assign echo_desce = ~echo_s_q & echo_prev_q;

  contador_cm #(
    .CYCLES_PER_CM(CYCLES_PER_CM)
  ) u_contador (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .conta    (conta),
    .arredonda(arredonda),
`ifdef MEDIDA_ARREDONDA_EN
    .meio     (meio),
`endif
    .bcd      (bcd)
  );

  // The rising-edge cycle itself is counted so an N-cycle echo yields N ticks.
  always_comb begin
    estado_d   = estado_q;
    trig_cnt_d = trig_cnt_q;
    medida_d   = medida_q;
    clear      = 1'b0;
    conta      = 1'b0;
    arredonda  = 1'b0;
    case (estado_q)
      INICIAL: begin
        estado_d = INICIAL;
      end
      PREPARACAO: begin
        clear      = 1'b1;
        trig_cnt_d = '0;
        estado_d   = ENVIA_TRIGGER;
      end
      ENVIA_TRIGGER: begin
        trig_cnt_d = trig_cnt_q + TRIG_W'(1);
        if (trig_cnt_q == TRIG_LAST) estado_d = ESPERA_ECHO;
      end
      ESPERA_ECHO: begin
        if (echo_sobe) begin
          conta    = 1'b1;
          estado_d = MEDE;
        end
      end
      MEDE: begin
        if (echo_desce) begin
`ifdef MEDIDA_ARREDONDA_EN
          arredonda = meio;
`endif
          estado_d = ARMAZENA;
        end else begin
          conta = echo_s_q;
        end
      end
      ARMAZENA: begin
        if (!medir) medida_d = bcd;
        estado_d = FINAL_MEDIDA;
      end
      FINAL_MEDIDA: begin
        estado_d = INICIAL;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase
    // A new request always restarts, abandoning any measurement in flight.
    if (medir) estado_d = PREPARACAO;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= INICIAL;
      trig_cnt_q  <= '0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_prev_q <= 1'b0;
      trigger_q   <= 1'b0;
      pronto_q    <= 1'b0;
      medida_q    <= '0;
    end else begin
      estado_q    <= estado_d;
      trig_cnt_q  <= trig_cnt_d;
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      echo_prev_q <= echo_s_q;
      trigger_q   <= (estado_d == ENVIA_TRIGGER);
      pronto_q    <= (estado_d == FINAL_MEDIDA);
      medida_q    <= medida_d;
    end
  end

  assign trigger   = trigger_q;
  assign pronto    = pronto_q;
  assign medida    = medida_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_interface_hcsr04.sv
// Randomised self-checking bench for interface_hcsr04 with scaled-down timing
// (20-cycle trigger, 7 cycles per cm) and an arithmetic distance model.
module tb_interface_hcsr04;

  localparam int unsigned CLK_HZ = 2_000_000;
  localparam int unsigned TRIG_US = 10;
  localparam int unsigned CPC = 7;
  localparam int TC = CLK_HZ / 1_000_000 * TRIG_US;

  logic        clock;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic        pronto;
  logic [11:0] medida;
  logic [2:0]  db_estado;

  int total = 0;
  int bad = 0;

  int pronto_cnt = 0;
  int pronto_long = 0;
  logic pronto_prev = 1'b0;
  logic [11:0] medida_at_pronto = 12'h000;
  int trig_run = 0;
  int trig_len_last = 0;
  int trig_cnt = 0;

  int base_pronto = 0;
  logic [11:0] last_exp = 12'h000;

  interface_hcsr04 #(
    .CLK_HZ(CLK_HZ),
    .TRIGGER_US(TRIG_US),
    .CYCLES_PER_CM(CPC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .medir(medir),
    .echo(echo),
    .trigger(trigger),
    .pronto(pronto),
    .medida(medida),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    pronto_prev <= pronto;
    if (pronto) begin
      pronto_cnt       <= pronto_cnt + 1;
      medida_at_pronto <= medida;
      if (pronto_prev) pronto_long <= pronto_long + 1;
    end
    if (trigger) begin
      trig_run <= trig_run + 1;
    end else if (trig_run != 0) begin
      trig_len_last <= trig_run;
      trig_cnt      <= trig_cnt + 1;
      trig_run      <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Distance in whole cm from echo width, then BCD-encoded.
  function automatic logic [11:0] model_bcd(input int w);
    int cm;
    cm = w / CPC;
`ifdef MEDIDA_ARREDONDA_EN
    if ((w % CPC) >= (CPC / 2)) cm++;
`endif
    if (cm > 999) cm = 999;
    return 12'((cm / 100) * 256 + ((cm / 10) % 10) * 16 + (cm % 10));
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_meas(input string tag);
    int t0;
    base_pronto = pronto_cnt;
    t0 = trig_cnt;
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
    for (int i = 0; i < 200 && trig_cnt == t0; i++) @(negedge clock);
    check({tag, "_trig_seen"}, 32'(trig_cnt - t0), 32'd1);
    check({tag, "_trig_len"}, 32'(trig_len_last), 32'(TC));
    check({tag, "_medida_held"}, 32'(medida), 32'(last_exp));
  endtask

  task automatic echo_pulse(input int w);
    @(negedge clock) echo = 1'b1;
    repeat (w) @(negedge clock);
    echo = 1'b0;
  endtask

  task automatic finish_meas(input string tag, input int w);
    logic [11:0] e;
    e = model_bcd(w);
    wait_cycles(12);
    check({tag, "_pronto_cnt"}, 32'(pronto_cnt - base_pronto), 32'd1);
    check({tag, "_medida_pronto"}, 32'(medida_at_pronto), 32'(e));
    check({tag, "_medida"}, 32'(medida), 32'(e));
    check({tag, "_estado"}, 32'(db_estado), 32'd0);
    last_exp = e;
  endtask

  task automatic full_meas(input string tag, input int w);
    start_meas(tag);
    wait_cycles(int'($urandom_range(1, 20)));
    echo_pulse(w);
    finish_meas(tag, w);
  endtask

  initial begin
    reset = 1'b0;
    medir = 1'b0;
    echo  = 1'b0;
    #3;
    check("rst_trigger", 32'(trigger), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_medida", 32'(medida), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2);

    full_meas("basic15", 15 * CPC);
    full_meas("round_hi", 15 * CPC + CPC / 2);
    full_meas("round_lo", 15 * CPC + CPC / 2 - 1);
    full_meas("one_cycle", 1);
    full_meas("exact999", 999 * CPC);
    full_meas("saturate", 1200 * CPC);

    // Missing echo: the block idles in espera_echo until re-requested.
    start_meas("abort1");
    wait_cycles(200);
    check("abort_wait_state", 32'(db_estado), 32'd3);
    check("abort_no_pronto", 32'(pronto_cnt - base_pronto), 32'd0);
    full_meas("abort2", CPC);

    // Echo already high when waiting starts must not be counted.
    echo = 1'b1;
    wait_cycles(5);
    start_meas("echo_hi");
    wait_cycles(50);
    check("echo_hi_wait", 32'(db_estado), 32'd3);
    echo = 1'b0;
    wait_cycles(20);
    echo_pulse(10 * CPC);
    finish_meas("echo_hi", 10 * CPC);

    // Asynchronous reset during mede.
    start_meas("rst_mid");
    wait_cycles(5);
    @(negedge clock) echo = 1'b1;
    wait_cycles(30);
    check("rst_mid_in_mede", 32'(db_estado), 32'd4);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_trigger", 32'(trigger), 32'd0);
    check("rst_mid_pronto", 32'(pronto), 32'd0);
    check("rst_mid_medida", 32'(medida), 32'd0);
    check("rst_mid_estado", 32'(db_estado), 32'd0);
    @(negedge clock) echo = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    last_exp = 12'h000;
    wait_cycles(3);
    full_meas("after_rst", 23 * CPC + 1);

    for (int k = 0; k < 12; k++) begin
      int w;
      if (k % 4 == 3) w = int'($urandom_range(1, 1100 * CPC));
      else w = int'($urandom_range(1, 60 * CPC));
      full_meas($sformatf("rand%0d", k), w);
    end

    check("pronto_single_cycle", 32'(pronto_long), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
